pipe_skid_stage: RTL and testbench
==================================

# pipe_skid_stage

Parametrised elastic pipeline stage replacing the fixed-field stall/flush inter-segment registers. It carries an opaque packed payload of `DW` bits between two pipeline segments using a valid/ready handshake, with a 2-entry skid buffer so `in_ready` is registered. It also provides a flush that squashes in-flight entries and saturating stall/drop counters for performance debug. One instance sits at each of IF/ID, ID/EX, EX/MEM and MEM/WB.

## Interface
Parameters:
- `DW`, default 64: payload width in bits; minimum 1.
- `RST_PAYLOAD`, default `{DW{1'b0}}`: value loaded into the payload registers on reset and on flush. IF/ID uses the PC reset value in its PC field.
- `CNT_W`, default 16: width of the performance counters; minimum 2.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `flush`  in  1  squash all held entries and the current input.
- `in_valid`  in  1  upstream payload valid.
- `in_ready`  out  1  stage can accept; registered.
- `in_data`  in  DW  upstream payload.
- `out_valid`  out  1  downstream payload valid; registered.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  DW  downstream payload; driven directly by the main register.
- `occupancy`  out  2  entries held, 0..2.
- `stall_cnt`  out  CNT_W  cycles with `out_valid && !out_ready`; saturating.
- `drop_cnt`  out  CNT_W  valid entries discarded by flush; saturating.

## Operation
- Storage:
  - Main register M holds `M_data`. `out_valid` is asserted when state is ONE or FULL.
  - Skid register S holds `S_data`.
- Handshakes: `in_fire = in_valid && in_ready`; `out_fire = out_valid && out_ready`.
- States and signals:
  - EMPTY (occupancy 0): `in_ready`=1, `out_valid`=0.
  - ONE (occupancy 1): `in_ready`=1, `out_valid`=1.
  - FULL (occupancy 2): `in_ready`=0, `out_valid`=1.
- Transitions (when neither `rst` nor `flush` is asserted):
  - EMPTY, `in_fire` → ONE; M ← `in_data`.
  - ONE, `in_fire && out_fire` → ONE; M ← `in_data`.
  - ONE, `in_fire && !out_ready` → FULL; S ← `in_data`; M unchanged.
  - ONE, `!in_fire && out_fire` → EMPTY; M retains its value.
  - FULL, `out_fire` → ONE; M ← S. Input is not accepted because `in_ready`=0.
  - All other cases: hold.
- Priority: `rst` > `flush` > normal operation.
- Flush:
  - Next state EMPTY.
  - M and S ← `RST_PAYLOAD`.
  - `in_ready` ← 1.
  - Input presented in the flush cycle is discarded, even if `in_ready` was 1; upstream is flushed in the same cycle.
  - `drop_cnt` += current occupancy (0, 1 or 2), saturating at all-ones. The input being discarded is not counted.
- `stall_cnt`:
  - +1 in every non-reset cycle with `out_valid && !out_ready`, including flush cycles.
  - Saturates at all-ones.
  - Cleared only by `rst`.
- Reset values:
  - State EMPTY; `out_valid`=0; `in_ready`=1; `occupancy`=0.
  - M, S = `RST_PAYLOAD`, so `out_data`=`RST_PAYLOAD`.
  - `stall_cnt`=0, `drop_cnt`=0.
  - Inputs are ignored while `rst` is high.
- Reset mid-operation: held entries are lost and are not counted in `drop_cnt`.

## Timing
- Latency: an input accepted at edge k appears on `out_data`/`out_valid` after edge k and is valid in cycle k+1.
- No combinational path from input to output:
  - `in_ready` depends only on state.
  - `out_valid` and `out_data` come only from registers.
- Throughput is 1 transfer per cycle while `out_ready`=1.
- When `out_ready` deasserts, at most one further input is absorbed, into S.
- After `out_ready` is raised in FULL, `in_ready` returns to 1 one cycle later.
- Order is preserved: M always holds the older entry and S the younger.
- Counter and state updates all take effect on the same edge.

## Test plan
Parameters for all scenarios: `DW`=32, `RST_PAYLOAD`=32'h1c00_0000, `CNT_W`=4.

1. **Reset:** hold `rst` for 2 cycles with `in_valid`=1 and `in_data`=32'hDEAD → afterwards `out_valid`=0, `in_ready`=1, `out_data`=32'h1c00_0000, both counters 0, `occupancy`=0.
2. **Streaming:** `out_ready`=1; send 1, 2, 3 on consecutive cycles → `out_data` shows 1, 2, 3 in cycles k+1 to k+3; `in_ready` stays 1; `stall_cnt`=0.
3. **Backpressure and skid:** `out_ready`=0; send A=5 then B=6 → `occupancy`=2 and `in_ready`=0, with C=7 held upstream. Raise `out_ready` → outputs 5, 6, 7 in order, no loss or duplication; `stall_cnt` equals the number of stalled cycles.
4. **Flush while FULL:** with `in_valid`=1 and `in_data`=9, assert `flush` → next cycle EMPTY, `out_data`=32'h1c00_0000, `drop_cnt`=2, and 9 never appears at the output.
5. **Saturation:** hold `out_valid`=1 with `out_ready`=0 for 20 cycles → `stall_cnt`=4'hF and stays there. Apply 8 flushes while FULL → `drop_cnt`=4'hF.
6. **Priority:** assert `rst` and `flush` together while FULL → reset values result and `drop_cnt`=0.

Source files
------------

// File: rtl/pipe_skid_stage.sv
// Elastic valid/ready pipeline stage with a 2-entry skid buffer, flush,
// and saturating stall/drop counters for performance debug.
module pipe_skid_stage #(
    parameter int              DW          = 64,
    parameter logic [DW-1:0]   RST_PAYLOAD = '0,
    parameter int              CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state_p0, state_nxt;
    logic [DW-1:0]     m_data_p0, s_data_p0;
    logic              m_load_in, m_load_s, s_load_in;
    logic              in_fire, out_fire;
    logic [CNT_W-1:0]  stall_cnt_p0, drop_cnt_p0;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [1:0]       b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
        if (sum[CNT_W])
            return '1;
        return sum[CNT_W-1:0];
    endfunction

    assign in_ready  = (state_p0 != FULL);
    assign out_valid = (state_p0 != EMPTY);
    assign out_data  = m_data_p0;
    assign occupancy = state_p0;
    assign stall_cnt = stall_cnt_p0;
    assign drop_cnt  = drop_cnt_p0;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_comb begin
        state_nxt = state_p0;
        m_load_in = 1'b0;
        m_load_s  = 1'b0;
        s_load_in = 1'b0;
        case (state_p0)
            EMPTY: begin
                if (in_fire) begin
                    state_nxt = ONE;
                    m_load_in = 1'b1;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    m_load_in = 1'b1;
                end else if (in_fire) begin
                    state_nxt = FULL;
                    s_load_in = 1'b1;
                end else if (out_fire) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_nxt = ONE;
                    m_load_s  = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // Stage boundary: control state and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p0     <= EMPTY;
            stall_cnt_p0 <= '0;
            drop_cnt_p0  <= '0;
        end else begin
            if (out_valid && !out_ready)
                stall_cnt_p0 <= sat_add(stall_cnt_p0, 2'd1);
            if (flush) begin
                state_p0    <= EMPTY;
                drop_cnt_p0 <= sat_add(drop_cnt_p0, occupancy);
            end else begin
                state_p0 <= state_nxt;
            end
        end
    end

    // Stage boundary: payload registers; M always holds the older entry.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            m_data_p0 <= RST_PAYLOAD;
            s_data_p0 <= RST_PAYLOAD;
        end else begin
            if (m_load_in)
                m_data_p0 <= in_data;
            else if (m_load_s)
                m_data_p0 <= s_data_p0;
            if (s_load_in)
                s_data_p0 <= in_data;
        end
    end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: vector table for the main sequences, hand-written
// saturation/priority sequences, and an in-order scoreboard on every transfer.
module tb_pipe_skid_stage;

    localparam logic [31:0] RSTP = 32'h1c00_0000;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_data, out_data;
    logic [1:0]  occupancy;
    logic [3:0]  stall_cnt, drop_cnt;

    int checks   = 0;
    int failures = 0;
    logic [31:0] sb_q[$];

    pipe_skid_stage #(.DW(32), .RST_PAYLOAD(RSTP), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy), .stall_cnt(stall_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        fl;
        logic        ev;
        logic        er;
        logic [1:0]  eocc;
        logic [31:0] edata;
        logic [3:0]  estall;
        logic [3:0]  edrop;
    } vec_t;

    vec_t vt[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Drive one cycle; scoreboard bookkeeping happens mid-cycle, before the edge.
    task automatic step(input logic iv, input logic [31:0] d, input logic ordy,
                        input logic fl, input logic r);
        logic [31:0] exp_d;
        rst = r; flush = fl; in_valid = iv; in_data = d; out_ready = ordy;
        @(negedge clk);
        if (!r)
            chk("occupancy_vs_sb", {30'd0, occupancy}, sb_q.size());
        if (r || fl) begin
            sb_q.delete();
        end else begin
            if (out_valid && ordy) begin
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    exp_d = sb_q.pop_front();
                    chk("sb_data", out_data, exp_d);
                end
            end
            if (iv && in_ready)
                sb_q.push_back(d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic ev, input logic er,
                             input logic [1:0] eocc, input logic [31:0] edata,
                             input logic [3:0] estall, input logic [3:0] edrop);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, {31'd0, ev});
        chk({tag, "_in_ready"},  {31'd0, in_ready},  {31'd0, er});
        chk({tag, "_occupancy"}, {30'd0, occupancy}, {30'd0, eocc});
        chk({tag, "_out_data"},  out_data, edata);
        chk({tag, "_stall_cnt"}, {28'd0, stall_cnt}, {28'd0, estall});
        chk({tag, "_drop_cnt"},  {28'd0, drop_cnt},  {28'd0, edrop});
    endtask

    initial begin
        //         iv    d      ordy  fl    ev    er    occ   data   stall drop
        vt[0]  = '{1'b1, 32'd1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 32'd1, 4'd0, 4'd0};
        vt[1]  = '{1'b1, 32'd2, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 32'd2, 4'd0, 4'd0};
        vt[2]  = '{1'b1, 32'd3, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 32'd3, 4'd0, 4'd0};
        vt[3]  = '{1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 32'd3, 4'd0, 4'd0};
        vt[4]  = '{1'b1, 32'd5, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 32'd5, 4'd0, 4'd0};
        vt[5]  = '{1'b1, 32'd6, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 32'd5, 4'd1, 4'd0};
        vt[6]  = '{1'b1, 32'd7, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 32'd5, 4'd2, 4'd0};
        vt[7]  = '{1'b1, 32'd7, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 32'd6, 4'd2, 4'd0};
        vt[8]  = '{1'b1, 32'd7, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 32'd7, 4'd2, 4'd0};
        vt[9]  = '{1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 32'd7, 4'd2, 4'd0};
        vt[10] = '{1'b1, 32'd10, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 32'd10, 4'd2, 4'd0};
        vt[11] = '{1'b1, 32'd11, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 32'd10, 4'd3, 4'd0};
        vt[12] = '{1'b1, 32'd9, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, RSTP, 4'd4, 4'd2};
        vt[13] = '{1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, RSTP, 4'd4, 4'd2};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset with live input presented.
        step(1'b1, 32'h0000_DEAD, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h0000_DEAD, 1'b0, 1'b0, 1'b1);
        chk_state("reset", 1'b0, 1'b1, 2'd0, RSTP, 4'd0, 4'd0);

        // Streaming, backpressure/skid, flush while FULL.
        for (int i = 0; i < 14; i++) begin
            step(vt[i].iv, vt[i].d, vt[i].ordy, vt[i].fl, 1'b0);
            chk_state($sformatf("vec%0d", i), vt[i].ev, vt[i].er, vt[i].eocc,
                      vt[i].edata, vt[i].estall, vt[i].edrop);
        end

        // Stall counter saturation.
        step(1'b1, 32'd20, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++)
            step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("stall_saturated", {28'd0, stall_cnt}, 32'hF);
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("stall_stays_saturated", {28'd0, stall_cnt}, 32'hF);

        // Drop counter saturation: 2 + 2*6 = 14, then clamps at 15.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 32'd100 + i, 1'b0, 1'b0, 1'b0);
            step(1'b1, 32'd200 + i, 1'b0, 1'b0, 1'b0);
            chk("full_before_flush", {30'd0, occupancy}, 32'd2);
            step(1'b1, 32'd9, 1'b0, 1'b1, 1'b0);
            if (i == 5)
                chk("drop_after_6_flushes", {28'd0, drop_cnt}, 32'hE);
        end
        chk("drop_saturated", {28'd0, drop_cnt}, 32'hF);
        chk("flush_out_data", out_data, RSTP);

        // rst and flush together while FULL.
        step(1'b1, 32'd30, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'd31, 1'b0, 1'b0, 1'b0);
        chk("full_before_rst", {30'd0, occupancy}, 32'd2);
        step(1'b1, 32'd32, 1'b0, 1'b1, 1'b1);
        chk_state("priority", 1'b0, 1'b1, 2'd0, RSTP, 4'd0, 4'd0);

        // Normal operation resumes after reset.
        step(1'b1, 32'd42, 1'b1, 1'b0, 1'b0);
        chk("post_reset_data", out_data, 32'd42);
        step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        chk("sb_drained", sb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
